// File: rtl/io_seg_queue.sv
// Memory-mapped seven-segment message queue: bus pushes display words into a
// circular buffer, each word is shown for DWELL cycles; includes a blink countdown.
module io_seg_queue #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DWELL      = 100_000_000,
  parameter logic [31:0] SEG_ADDR   = 32'hFFFF_FC00,
  parameter logic [31:0] STAT_ADDR  = 32'hFFFF_FC04,
  parameter logic [31:0] CTRL_ADDR  = 32'hFFFF_FC08,
  parameter logic [31:0] BLINK_ADDR = 32'hFFFF_FC0C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IOWrite,
  input  logic              IORead,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       Read_data_2,
  output logic [31:0]       io_rdata,
  output logic              io_hit,
  output logic [DATA_W-1:0] IO_seg_out,
  output logic              seg_valid,
  output logic              IO_blink_out,
  output logic              q_full,
  output logic              q_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      DWELL_LD = 32'(DWELL - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nx_c;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, pause_q, pause_d, pend_q, pend_d;
  logic [31:0]       dwell_q, dwell_d, blink_q, blink_d;
  logic [DATA_W-1:0] seg_q, seg_d;
  logic              valid_q, valid_d, blink_on_q, full_q, empty_q;
  logic              seg_wr_c, ctrl_wr_c, blink_wr_c, flush_c, pop_c, push_c;
  logic [DATA_W-1:0] wdata_c;

  always_comb begin
    seg_wr_c   = IOWrite && (ALU_result == SEG_ADDR);
    ctrl_wr_c  = IOWrite && (ALU_result == CTRL_ADDR);
    blink_wr_c = IOWrite && (ALU_result == BLINK_ADDR);
    flush_c    = ctrl_wr_c && Read_data_2[0];
    wdata_c    = Read_data_2[DATA_W-1:0];
    head_nx_c  = head_q + PTR_W'(1);
    pop_c      = (state_q == S_SHOW) && !pause_q && (dwell_q == '0) && !flush_c;
    push_c     = seg_wr_c && !flush_c && ((count_q != FULL_CNT) || pop_c);
  end

  // Queue bookkeeping, display FSM and blink countdown
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pause_d = pause_q;
    dwell_d = dwell_q;
    seg_d   = seg_q;
    valid_d = valid_q;
    pend_d  = (count_q != '0);
    blink_d = blink_q;

    if (push_c) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      head_d = head_nx_c;
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end

    if (seg_wr_c && !push_c && !flush_c) begin
      ovf_d = 1'b1;
    end
    if (ctrl_wr_c) begin
      if (Read_data_2[1]) begin
        ovf_d = 1'b0;
      end
      pause_d = Read_data_2[2];
    end

    // The pending flag delays the first load one cycle after the count goes nonzero
    unique case (state_q)
      S_IDLE: begin
        seg_d   = '0;
        valid_d = 1'b0;
        if (pend_q && (count_q != '0)) begin
          seg_d   = mem_q[head_q];
          valid_d = 1'b1;
          dwell_d = DWELL_LD;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (pop_c) begin
          if ((count_q > CNT_W'(1)) || push_c) begin
            // With one entry left, the same-cycle push becomes the new head
            seg_d   = (count_q > CNT_W'(1)) ? mem_q[head_nx_c] : wdata_c;
            dwell_d = DWELL_LD;
          end else begin
            seg_d   = '0;
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end else if (!pause_q) begin
          dwell_d = dwell_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_c) begin
      count_d = '0;
      head_d  = tail_q;
      state_d = S_IDLE;
      seg_d   = '0;
      valid_d = 1'b0;
      pend_d  = 1'b0;
    end

    if (blink_wr_c) begin
      blink_d = Read_data_2;
    end else if (blink_q != '0) begin
      blink_d = blink_q - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      pause_q    <= 1'b0;
      pend_q     <= 1'b0;
      dwell_q    <= '0;
      blink_q    <= '0;
      seg_q      <= '0;
      valid_q    <= 1'b0;
      blink_on_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      pause_q    <= pause_d;
      pend_q     <= pend_d;
      dwell_q    <= dwell_d;
      blink_q    <= blink_d;
      seg_q      <= seg_d;
      valid_q    <= valid_d;
      blink_on_q <= (blink_d != '0);
      full_q     <= (count_d == FULL_CNT);
      empty_q    <= (count_d == '0);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[tail_q] <= wdata_c;
    end
  end

  always_comb begin
    io_hit   = 1'b0;
    io_rdata = '0;
    if (IORead) begin
      if (ALU_result == STAT_ADDR) begin
        io_hit   = 1'b1;
        io_rdata = {16'h0, 8'(count_q), 5'h0, ovf_q, full_q, empty_q};
      end else if (ALU_result == CTRL_ADDR) begin
        io_hit   = 1'b1;
        io_rdata = {29'h0, pause_q, 2'b00};
      end else if (ALU_result == BLINK_ADDR) begin
        io_hit   = 1'b1;
        io_rdata = blink_q;
      end
    end
  end

  assign IO_seg_out   = seg_q;
  assign seg_valid    = valid_q;
  assign IO_blink_out = blink_on_q;
  assign q_full       = full_q;
  assign q_empty      = empty_q;

endmodule

// File: tb/tb_io_seg_queue.sv
// Bench for io_seg_queue: directed table, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_io_seg_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DWELL  = 3;
  localparam logic [31:0] SEG  = 32'hFFFF_FC00;
  localparam logic [31:0] STAT = 32'hFFFF_FC04;
  localparam logic [31:0] CTRL = 32'hFFFF_FC08;
  localparam logic [31:0] BLNK = 32'hFFFF_FC0C;

  logic              clk = 1'b0;
  logic              rst, IOWrite, IORead;
  logic [31:0]       ALU_result, Read_data_2, io_rdata;
  logic              io_hit, seg_valid, IO_blink_out, q_full, q_empty;
  logic [DATA_W-1:0] IO_seg_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_seg_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .IOWrite(IOWrite), .IORead(IORead),
    .ALU_result(ALU_result), .Read_data_2(Read_data_2),
    .io_rdata(io_rdata), .io_hit(io_hit), .IO_seg_out(IO_seg_out),
    .seg_valid(seg_valid), .IO_blink_out(IO_blink_out),
    .q_full(q_full), .q_empty(q_empty)
  );

  // Reference model: queue contents, whether the head is on display, dwell left
  logic [DATA_W-1:0] mq[$];
  bit                m_show, m_prev_ne, m_pause, m_ovf;
  int unsigned       m_remain;
  logic [31:0]       m_blink;

  task automatic m_reset();
    mq.delete();
    m_show = 0; m_prev_ne = 0; m_pause = 0; m_ovf = 0;
    m_remain = 0; m_blink = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == STAT) return {16'h0, 8'(mq.size()), 5'h0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
    if (a == CTRL) return {29'h0, m_pause, 2'b00};
    if (a == BLNK) return m_blink;
    return 32'h0;
  endfunction

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    int  old_sz;
    bit  segw, flush, pop, push, p_old;
    old_sz = mq.size();
    p_old  = m_pause;
    segw   = w && (a == SEG);
    flush  = w && (a == CTRL) && d[0];
    pop    = m_show && !p_old && (m_remain == 0) && !flush;
    push   = segw && !flush && (old_sz < DEPTH || pop);
    if (segw && !push && !flush) m_ovf = 1;
    if (w && a == CTRL) begin
      if (d[1]) m_ovf = 0;
      m_pause = d[2];
    end
    if (flush) begin
      mq.delete();
      m_show = 0;
      m_prev_ne = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d[DATA_W-1:0]);
      if (pop) begin
        m_show = (mq.size() != 0);
        m_remain = DWELL - 1;
      end else if (m_show) begin
        if (!p_old) m_remain--;
      end else if (m_prev_ne && old_sz != 0) begin
        m_show = 1;
        m_remain = DWELL - 1;
      end
      m_prev_ne = (old_sz != 0);
    end
    if (w && a == BLNK) m_blink = d;
    else if (m_blink != 0) m_blink = m_blink - 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one bus access and compare all outputs with the model before the edge
  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    IOWrite = w; IORead = r; ALU_result = a; Read_data_2 = d;
    #1;
    chk("seg_out", 32'(IO_seg_out), m_show ? 32'(mq[0]) : 32'h0);
    chk("seg_valid", 32'(seg_valid), 32'(m_show));
    chk("blink_out", 32'(IO_blink_out), 32'(m_blink != 0));
    chk("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
    chk("q_empty", 32'(q_empty), 32'(mq.size() == 0));
    if (r) begin
      chk("io_hit", 32'(io_hit), 32'(a == STAT || a == CTRL || a == BLNK));
      chk("io_rdata", io_rdata, m_read(a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(IOWrite, ALU_result, Read_data_2);
    #1;
  endtask

  task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    drive(w, r, a, d);
    tick();
  endtask

  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(0, 1, a, 32'h0);
    chk(name, io_rdata, exp);
    tick();
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] seg;
    logic        vld;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] held;
    bit                found;
    int                hc;

    tbl[0]  = '{1'b1, 1'b0, SEG,  32'h11, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, SEG,  32'h22, 32'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, SEG,  32'h33, 32'h00, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h11, 1'b1, 32'h0300};
    tbl[4]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h11, 1'b1, 32'h0300};
    tbl[5]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h11, 1'b1, 32'h0300};
    tbl[6]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h22, 1'b1, 32'h0200};
    tbl[7]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h22, 1'b1, 32'h0200};
    tbl[8]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h22, 1'b1, 32'h0200};
    tbl[9]  = '{1'b0, 1'b1, STAT, 32'h0,  32'h33, 1'b1, 32'h0100};
    tbl[10] = '{1'b0, 1'b1, STAT, 32'h0,  32'h33, 1'b1, 32'h0100};
    tbl[11] = '{1'b0, 1'b1, STAT, 32'h0,  32'h33, 1'b1, 32'h0100};
    tbl[12] = '{1'b0, 1'b1, STAT, 32'h0,  32'h00, 1'b0, 32'h0001};
    tbl[13] = '{1'b0, 1'b1, CTRL, 32'h0,  32'h00, 1'b0, 32'h0000};

    rst = 1'b1; IOWrite = 0; IORead = 0; ALU_result = '0; Read_data_2 = '0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_seg", 32'(IO_seg_out), 32'h0);
    chk("rst_empty", 32'(q_empty), 32'h1);
    rst = 1'b0;
    read_expect("rst_stat", STAT, 32'h0000_0001);

    // Three pushes, each shown for DWELL cycles after a two-cycle latency
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_seg", i), 32'(IO_seg_out), tbl[i].seg);
      chk($sformatf("tbl%0d_vld", i), 32'(seg_valid), 32'(tbl[i].vld));
      if (tbl[i].r) chk($sformatf("tbl%0d_rd", i), io_rdata, tbl[i].rd);
      tick();
    end

    // Overflow while paused, then clear it
    cyc(1, 0, CTRL, 32'h4);
    for (int i = 0; i < 5; i++) cyc(1, 0, SEG, 32'hA0 + 32'(i));
    read_expect("ovf_stat", STAT, 32'h0000_0406);
    cyc(1, 0, CTRL, 32'h2);
    read_expect("ovf_clr_stat", STAT, 32'h0000_0402);

    // Push into a full queue on the cycle the dwell expires
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_show && m_remain == 0 && !m_pause) found = 1;
      else cyc(0, 0, 32'h0, 32'h0);
    end
    chk("collide_wait", 32'(found), 32'h1);
    cyc(1, 0, SEG, 32'hAB);
    read_expect("collide_stat", STAT, 32'h0000_0402);

    // Pause holds the word, unpause resumes, flush empties
    cyc(1, 0, CTRL, 32'h4);
    held = mq[0];
    for (int i = 0; i < 8; i++) cyc(0, 0, 32'h0, 32'h0);
    drive(0, 1, CTRL, 32'h0);
    chk("pause_hold", 32'(IO_seg_out), 32'(held));
    chk("pause_vld", 32'(seg_valid), 32'h1);
    chk("pause_rd", io_rdata, 32'h4);
    tick();
    cyc(1, 0, CTRL, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 32'h0);
    cyc(1, 0, CTRL, 32'h1);
    drive(0, 1, STAT, 32'h0);
    chk("flush_vld", 32'(seg_valid), 32'h0);
    chk("flush_stat", io_rdata, 32'h0000_0001);
    tick();

    // Blink: five high cycles, countdown readback, cancel
    cyc(1, 0, BLNK, 32'd5);
    hc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 32'h0, 32'h0);
      if (IO_blink_out) hc++;
      tick();
    end
    chk("blink_len", 32'(hc), 32'd5);
    cyc(1, 0, BLNK, 32'd5);
    cyc(0, 0, 32'h0, 32'h0);
    read_expect("blink_rd", BLNK, 32'd4);
    cyc(1, 0, BLNK, 32'd7);
    cyc(0, 0, 32'h0, 32'h0);
    cyc(1, 0, BLNK, 32'd0);
    drive(0, 0, 32'h0, 32'h0);
    chk("blink_cancel", 32'(IO_blink_out), 32'h0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [31:0] d;
      op = $urandom_range(0, 99);
      if (op < 40) begin
        cyc(1, 0, SEG, $urandom());
      end else if (op < 55) begin
        cyc(0, 1, STAT, 32'h0);
      end else if (op < 62) begin
        d = '0;
        d[0] = ($urandom_range(0, 5) == 0);
        d[1] = 1'($urandom_range(0, 1));
        d[2] = ($urandom_range(0, 3) == 0);
        d[31:3] = 29'($urandom());
        cyc(1, 0, CTRL, d);
      end else if (op < 70) begin
        cyc(1, 0, BLNK, 32'($urandom_range(0, 6)));
      end else if (op < 76) begin
        cyc(0, 1, CTRL, 32'h0);
      end else if (op < 80) begin
        cyc(0, 1, BLNK, 32'h0);
      end else if (op < 85) begin
        cyc(1, 0, 32'hFFFF_FC10, $urandom());
      end else if (op < 90) begin
        cyc(0, 1, (op[0] ? 32'h0000_1000 : SEG), 32'h0);
      end else begin
        cyc(0, 0, 32'h0, 32'h0);
      end
    end

    // Asynchronous reset mid-display with three entries queued
    cyc(1, 0, CTRL, 32'h3);
    cyc(1, 0, SEG, 32'h51);
    cyc(1, 0, SEG, 32'h52);
    cyc(1, 0, SEG, 32'h53);
    cyc(0, 0, 32'h0, 32'h0);
    chk("pre_rst_show", 32'(m_show), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_seg", 32'(IO_seg_out), 32'h0);
    chk("arst_vld", 32'(seg_valid), 32'h0);
    chk("arst_blink", 32'(IO_blink_out), 32'h0);
    chk("arst_full", 32'(q_full), 32'h0);
    chk("arst_empty", 32'(q_empty), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    read_expect("arst_stat", STAT, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
